// File: rtl/sync_chan_fifo.sv
// Synchronous single-clock channel FIFO with valid/ready handshakes on both sides.
// Define SYNC_CHAN_FIFO_BYPASS_EN for empty-FIFO cut-through of a write beat to the read side.
module sync_chan_fifo #(
  parameter int DATA_W   = 49,
  parameter int DEPTH    = 4,
  parameter int AFULL_TH = DEPTH - 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_W-1:0]            wdata,
  input  logic                         valid_i,
  output logic                         ready_o,
  output logic [DATA_W-1:0]            rdata,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         almost_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [AW:0]   PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW:0]       r_wptr;
  logic [AW:0]       r_rptr;
  logic [CW-1:0]     r_count;

  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic [DATA_W-1:0] w_head;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
  assign w_head  = r_mem[r_rptr[AW-1:0]];

  assign ready_o     = !w_full;
  assign count       = r_count;
  assign almost_full = (r_count >= CW'(AFULL_TH));

`ifdef SYNC_CHAN_FIFO_BYPASS_EN
  logic w_bypass;

  // An empty FIFO presents the incoming beat directly; a consumed beat never touches memory.
  assign w_bypass = w_empty && !rst && valid_i && ready_i;
  assign valid_o  = !w_empty || (valid_i && !rst);
  assign rdata    = (w_empty && !rst) ? wdata : w_head;
  assign w_pop    = !w_empty && ready_i;
  assign w_push   = valid_i && !w_full && !w_bypass;
`else
  assign valid_o = !w_empty;
  assign rdata   = w_head;
  assign w_pop   = !w_empty && ready_i;
  assign w_push  = valid_i && !w_full;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wptr[AW-1:0]] <= wdata;
        r_wptr                <= r_wptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_ONE;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_ONE;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_sync_chan_fifo.sv
// Self-checking bench for sync_chan_fifo: directed scenarios then random traffic against a queue model.
// Honours SYNC_CHAN_FIFO_BYPASS_EN when the bundle is built with it.
module tb_sync_chan_fifo;

  localparam int DATA_W   = 49;
  localparam int DEPTH    = 4;
  localparam int AFULL_TH = DEPTH - 1;
  localparam int CW       = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] wdata;
  logic              valid_i;
  logic              ready_o;
  logic [DATA_W-1:0] rdata;
  logic              valid_o;
  logic              ready_i;
  logic [CW-1:0]     count;
  logic              almost_full;

  sync_chan_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AFULL_TH(AFULL_TH)) dut (
    .clk        (clk),
    .rst        (rst),
    .wdata      (wdata),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .rdata      (rdata),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .count      (count),
    .almost_full(almost_full)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [DATA_W-1:0] q[$];
  logic              clean = 1'b0;
  logic              first = 1'b1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check outputs against the model, then advance the model past the edge.
  task automatic cycle(input logic v, input logic [DATA_W-1:0] d, input logic r, input logic rs);
    logic byp;
    logic push;
    logic pop;
    int   n;
    valid_i = v;
    wdata   = d;
    ready_i = r;
    rst     = rs;
    #2;
    n = q.size();
`ifdef SYNC_CHAN_FIFO_BYPASS_EN
    byp = (n == 0) && v && !rs;
`else
    byp = 1'b0;
`endif
    if (!first) begin
      check("count", 64'(count), 64'(n));
      check("ready_o", 64'(ready_o), 64'(n != DEPTH));
      check("almost_full", 64'(almost_full), 64'(n >= AFULL_TH));
      check("valid_o", 64'(valid_o), 64'((n != 0) || byp));
      if (n != 0)      check("rdata", 64'(rdata), 64'(q[0]));
      else if (byp)    check("rdata_bypass", 64'(rdata), 64'(d));
      else if (clean)  check("rdata_after_reset", 64'(rdata), 64'd0);
    end
    push = v && (n < DEPTH) && !(byp && r);
    pop  = r && (n != 0);
    @(posedge clk);
    #1;
    if (rs) begin
      q.delete();
      clean = 1'b1;
    end else begin
      if (pop) void'(q.pop_front());
      if (push) begin
        q.push_back(d);
        clean = 1'b0;
      end
    end
    first = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DATA_W-1:0] rnd;

    // Reset with push and pop requested; neither may take effect.
    cycle(1'b1, 49'h7, 1'b1, 1'b1);
    cycle(1'b1, 49'h7, 1'b1, 1'b1);

    // Fill to full with the consumer stalled.
    for (int i = 1; i <= 4; i++) cycle(1'b1, DATA_W'(i), 1'b0, 1'b0);

    // Write while full with a simultaneous pop: pop happens, write is dropped.
    cycle(1'b1, 49'h5, 1'b1, 1'b0);
    cycle(1'b0, 49'h0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 49'h0, 1'b1, 1'b0);

    // Streaming across several pointer wraps.
    for (int i = 'h10; i <= 'h1B; i++) cycle(1'b1, DATA_W'(i), 1'b1, 1'b0);
    cycle(1'b0, 49'h0, 1'b1, 1'b0);
    cycle(1'b0, 49'h0, 1'b1, 1'b0);

    // Reset in mid-operation discards the stored entries.
    for (int i = 0; i < 3; i++) cycle(1'b1, DATA_W'(32'h40 + i), 1'b0, 1'b0);
    cycle(1'b1, 49'h55, 1'b1, 1'b1);
    cycle(1'b0, 49'h0, 1'b0, 1'b0);
    cycle(1'b1, 49'hAA, 1'b0, 1'b0);
    cycle(1'b0, 49'h0, 1'b1, 1'b0);

    // Pops requested on an empty FIFO.
    for (int i = 0; i < 3; i++) cycle(1'b0, 49'h0, 1'b1, 1'b0);

    // Write to an empty FIFO with the consumer ready.
    cycle(1'b1, 49'h33, 1'b1, 1'b0);
    cycle(1'b0, 49'h0, 1'b1, 1'b0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      rnd = {$urandom, $urandom};
      cycle(1'($urandom_range(0, 1)), rnd, 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 60) == 0));
    end
    for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, 49'h0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sync_chan_fifo.md
SYNC_CHAN_FIFO -- requirements
Module: sync_chan_fifo

Interface
REQ-001 Parameter DATA_W, default 49, SHALL set the payload width in bits.
REQ-002 Parameter DEPTH, default 4, SHALL set the entry count; it SHALL be a power of two and at least 2.
REQ-003 Parameter AFULL_TH, default DEPTH-1, SHALL set the occupancy at or above which almost_full asserts; its legal range SHALL be 1..DEPTH.
REQ-004 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 wdata  input  DATA_W  write payload.
REQ-007 valid_i  input  1  write request.
REQ-008 ready_o  output  1  write accept, meaning the FIFO is not full.
REQ-009 rdata  output  DATA_W  read payload at the head entry.
REQ-010 valid_o  output  1  head entry is available.
REQ-011 ready_i  input  1  read request from the consumer.
REQ-012 count  output  $clog2(DEPTH+1)  current occupancy.
REQ-013 almost_full  output  1  high when count >= AFULL_TH.

Function
REQ-014 A push SHALL occur in a cycle where valid_i && ready_o; a pop SHALL occur in a cycle where valid_o && ready_i.
REQ-015 ready_o SHALL depend only on registered state: ready_o = (count != DEPTH), with no combinational path from ready_i or valid_i.
REQ-016 Write and read pointers SHALL be $clog2(DEPTH)+1 bits wide, with an extra wrap bit; full SHALL be low bits equal and wrap bits different; empty SHALL be both pointers equal.
REQ-017 Pointers SHALL wrap from DEPTH-1 to 0, toggling the wrap bit, with no lost or duplicated entry.
REQ-018 rdata SHALL equal mem[rptr low bits] combinationally; valid_o SHALL be !empty (in the non-bypass build).
REQ-019 Once asserted, valid_o and rdata SHALL hold stable until a pop.
REQ-020 count SHALL change as follows: +1 on push only, -1 on pop only, and unchanged on push and pop together or on neither.
REQ-021 When full, valid_i SHALL be ignored, with no pointer or memory change, even if ready_i pops in the same cycle; the freed slot SHALL become writable in the next cycle.
REQ-022 When empty, ready_i SHALL be ignored; count SHALL never underflow.
REQ-023 Write-to-read latency SHALL be 1 cycle: data pushed at edge N SHALL be visible with valid_o high after edge N.
REQ-024 Ordering SHALL be strict FIFO.

Reset
REQ-025 rst sampled high SHALL clear both pointers, count, and all mem entries to 0.
REQ-026 During and after reset: ready_o=1, valid_o=0, almost_full=0 (for AFULL_TH>=1), count=0, rdata=0.
REQ-027 Reset mid-operation SHALL discard all stored entries.
REQ-028 A push or pop request in the reset cycle SHALL have no effect.

Configuration
REQ-029 Macro SYNC_CHAN_FIFO_BYPASS_EN SHALL enable cut-through behaviour.
REQ-030 When it is defined and the FIFO is empty:
- valid_o SHALL equal valid_i and rdata SHALL equal wdata combinationally.
- If ready_i is also high, the beat SHALL pass in the same cycle with no memory write, and pointers and count SHALL be unchanged.
- If ready_i is low, the beat SHALL be stored normally.
REQ-031 When it is undefined, valid_o = !empty, there is no combinational path from valid_i or wdata to outputs, and latency is per REQ-023.

Verification
REQ-032 Reset, then 4 pushes (0x1..0x4) with ready_i=0 -> ready_o=0 after the 4th edge, count=4, almost_full=1 from count=3.
REQ-033 While full, set valid_i=1 with wdata=0x5 and ready_i=1 for 1 cycle -> 0x1 popped, 0x5 not stored, count=3, next cycle ready_o=1.
REQ-034 Continuous push and pop of 0x10..0x1B (12 beats, DEPTH=4, 3 pointer wraps) -> output sequence identical and gap-free after the first beat, count constant at 1.
REQ-035 Pulse rst with count=3 -> next cycle count=0, valid_o=0, ready_o=1, rdata=0; a later push of 0xAA is read back as 0xAA.
REQ-036 Build with SYNC_CHAN_FIFO_BYPASS_EN, empty FIFO, valid_i=ready_i=1, wdata=0x33 -> valid_o=1 and rdata=0x33 in the same cycle, count stays 0.
REQ-037 Empty FIFO, ready_i=1 for 3 cycles -> valid_o=0 and count=0 throughout, pointers unchanged.
